// File: rtl/lut_neuron_pkg.sv
// Shared defaults, derived table geometry and the controller state encoding
// for the programmable LUT neuron.
package lut_neuron_pkg;

  localparam int IN_BITS_DEF  = 6;
  localparam int OUT_BITS_DEF = 2;
  localparam int CFG_W_DEF    = 8;

  // Table geometry at the default parameters.
  localparam int ENTRIES = 2 ** IN_BITS_DEF;
  localparam int BEATS   = ENTRIES * OUT_BITS_DEF / CFG_W_DEF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/lut_neuron_ram.sv
// Truth-table storage: one lane per entry slot inside a config beat, so a
// whole beat is written in one cycle. Asynchronous read, no reset on the
// contents (maps onto distributed RAM). LANES and ROWS are powers of two.
module lut_neuron_ram #(
  parameter int ENTRY_W = 2,
  parameter int LANES   = 4,
  parameter int ROWS    = 16,
  localparam int LANE_W = $clog2(LANES),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ADDR_W = LANE_W + ROW_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ROW_W-1:0]           wr_row,
  input  logic [LANES*ENTRY_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [ENTRY_W-1:0]         rd_data
);

  logic [ENTRY_W-1:0] lane_rd [LANES];

  // Entry index = row*LANES + lane, so the low address bits select the lane.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ENTRY_W-1:0] mem [ROWS];

    // Lane gi takes its slice of the beat; entry 4k comes from the lowest bits.
    always_ff @(posedge clk) begin
      if (we) mem[wr_row] <= wr_data[gi*ENTRY_W +: ENTRY_W];
    end

    assign lane_rd[gi] = mem[rd_addr[ADDR_W-1:LANE_W]];
  end

  assign rd_data = lane_rd[rd_addr[LANE_W-1:0]];

endmodule

// File: rtl/lut_neuron_prog.sv
// Programmable LUT neuron: a streamed config loader fills the truth table,
// then indices are looked up with one-cycle latency behind a valid/ready
// output register.
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int CFG_W    = CFG_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                loaded
);

  localparam int TBL_ENTRIES = 2 ** IN_BITS;
  localparam int TBL_BEATS   = TBL_ENTRIES * OUT_BITS / CFG_W;
  localparam int LANES       = CFG_W / OUT_BITS;
  localparam int CNT_W       = $clog2(TBL_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TBL_BEATS - 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                cfg_done_reg;
  logic                loaded_reg;
  logic                out_valid_reg;
  logic [OUT_BITS-1:0] out_data_reg;
  logic [OUT_BITS-1:0] rd_data;
  logic                cfg_fire;
  logic                in_fire;

  // cfg_start always wins: it blocks both handshakes in the cycle it is seen.
  assign cfg_ready = (state_reg == LOAD) && !cfg_start;
  assign in_ready  = (state_reg == RUN) && !cfg_start && (!out_valid_reg || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  assign cfg_done  = cfg_done_reg;
  assign loaded    = loaded_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  lut_neuron_ram #(
    .ENTRY_W (OUT_BITS),
    .LANES   (LANES),
    .ROWS    (TBL_BEATS)
  ) u_ram (
    .clk     (clk),
    .we      (cfg_fire),
    .wr_row  (cnt_reg),
    .wr_data (cfg_data),
    .rd_addr (in_data),
    .rd_data (rd_data)
  );

  // Load controller: (re)start on cfg_start, count beats, flag completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      cnt_reg      <= '0;
      cfg_done_reg <= 1'b0;
      loaded_reg   <= 1'b0;
    end else begin
      cfg_done_reg <= 1'b0;
      if (cfg_start) begin
        state_reg  <= LOAD;
        cnt_reg    <= '0;
        loaded_reg <= 1'b0;
      end else if (cfg_fire) begin
        if (cnt_reg == LAST_BEAT) begin
          state_reg    <= RUN;
          cfg_done_reg <= 1'b1;
          loaded_reg   <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // Output register: capture the lookup on acceptance, hold until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (in_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= rd_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule
